systolic_sort_stream: RTL and testbench
=======================================

// Module: systolic_sort_stream
// PURPOSE
//  Batch sorter built on a parametrised odd-even transposition array of (key,tag) cells.
//  Accepts a batch of 1..DEPTH elements on a valid/ready stream and sorts it ascending or
//  descending; the direction is selected per batch. It stops early once the array is ordered,
//  then streams the batch out in order with a last flag.
//  Sits between a producer and consumer of keyed records; sorting is stable (ties keep arrival order).
// PARAMETERS
//  DEPTH  64  max elements per batch (>=2); number of array cells
//  KEY_W  32  key width; keys compare as unsigned
//  TAG_W   8  payload width; payload travels with its key, never compared
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      array accepts a beat this cycle
//  in_key     in   KEY_W  input key
//  in_tag     in   TAG_W  input payload
//  in_last    in   1      final beat of batch
//  in_descend in   1      direction; sampled on first accepted beat of a batch (1=descending)
//  out_valid  out  1      output beat valid
//  out_ready  in   1      consumer accepts beat
//  out_key    out  KEY_W  sorted key
//  out_tag    out  TAG_W  payload of out_key
//  out_last   out  1      final sorted beat of batch
//  busy       out  1      high in SORT or DRAIN
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=LOAD, count=0, all outputs 0 except in_ready, which is 1 from
//   the first cycle after reset. Cell contents are don't-care. Reset mid-batch discards the batch.
//  LOAD: in_ready=1. A beat is accepted when in_valid&in_ready; it writes cell[count] and count++.
//   The batch closes on accepting in_last, or on accepting the DEPTH-th beat (in_last ignored
//   there). On close, state moves to SORT on the next cycle and in_ready drops in the same cycle.
//  SORT: in_ready=0, busy=1. Phases alternate, one per cycle, starting with the even phase.
//   Even phase compares pairs (0,1),(2,3),...; odd phase compares (1,2),(3,4),...
//   Only cells < count take part; pairs touching cell >= count are idle.
//   A pair swaps only on strict disorder: asc swaps if key[i]>key[i+1]; desc swaps if key[i]<key[i+1].
//   Strict compare guarantees stability.
//   Exit: two consecutive phases (one even, one odd) with zero swaps -> DRAIN.
//   Hard bound: exit after count+1 phases regardless.
//   count=1 exits after 2 phases. Worst case SORT length = count+1 cycles.
//  DRAIN: busy=1, rd_ptr=0. out_key/out_tag=cell[rd_ptr], registered so data is valid with out_valid.
//   out_valid=1 from the first DRAIN cycle. Data holds stable while out_valid&!out_ready.
//   On handshake rd_ptr++. out_last=1 when rd_ptr==count-1.
//   On the last handshake: out_valid=0, count=0, state=LOAD, in_ready=1 on the next cycle.
//  Latency: last input accept -> first out_valid = 1 + SORT cycles + 1.
//   No overlap: the next batch cannot load until drain completes.
//  Widths: count and rd_ptr are $clog2(DEPTH+1) bits. No arithmetic on keys beyond compare.
// TESTING
//  1. Asc, keys 5,3,9,1 (tags 0..3), last on 4th -> out 1,3,5,9; tags 3,1,0,2; out_last on 9.
//  2. Desc, keys 7,7,2,7 (tags A,B,C,D) -> 7A,7B,7D,2C. Stable tie order; last on 2C.
//  3. Presorted asc batch of DEPTH keys 0..DEPTH-1 -> SORT lasts exactly 2 cycles.
//     Output is identical; batch closes without in_last.
//  4. Reverse-ordered DEPTH keys, asc -> sorted output. SORT <= DEPTH+1 cycles.
//     in_ready low throughout SORT/DRAIN.
//  5. Single beat key 0xFFFFFFFF with last -> one out beat, out_last=1. Random out_ready stalls
//     on multi-beat batches keep data stable.
//  6. Assert rst_n mid-DRAIN -> next cycle out_valid=0, busy=0, in_ready=1.
//     A new batch 2,1 -> 1,2.

Source files
------------

// File: rtl/systolic_sort_stream.sv
`default_nettype none
// ============================================================================
// Module   : systolic_sort_stream
// Brief    : Batch sorter on an odd-even transposition array of (key,tag)
//            cells. Loads 1..DEPTH beats, sorts ascending or descending
//            (stable), stops early once ordered, then streams out in order.
// Revision : 1.0  initial release
// ============================================================================
module systolic_sort_stream #(
  parameter int DEPTH = 64,
  parameter int KEY_W = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] in_key,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_last,
  input  logic             in_descend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [KEY_W-1:0] out_key,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [KEY_W-1:0] r_key  [DEPTH];
  logic [TAG_W-1:0] r_tag  [DEPTH];
  logic [KEY_W-1:0] w_nkey [DEPTH];
  logic [TAG_W-1:0] w_ntag [DEPTH];
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_phases;
  logic             r_phase;   // 0 = even phase, 1 = odd phase
  logic             r_quiet;   // previous phase made no swap
  logic             r_desc;
  logic             w_any_swap;

  logic          w_accept;
  logic          w_close;
  logic          w_out_hs;
  logic          w_sort_done;
  logic [CW-1:0] w_rd_next;

  assign w_accept    = in_valid & in_ready & (r_state == ST_LOAD);
  assign w_close     = w_accept & (in_last | (r_count == CW'(DEPTH - 1)));
  assign w_out_hs    = out_valid & out_ready;
  assign w_rd_next   = r_rd_ptr + CW'(1);
  // Two quiet phases in a row (one of each parity) means ordered; count+1
  // phases is always enough for odd-even transposition, so stop there too.
  assign w_sort_done = (r_quiet & ~w_any_swap) | (r_phases >= r_count);

  // One compare-exchange phase: disjoint pairs of the current parity inside the batch
  always_comb begin
    w_nkey     = r_key;
    w_ntag     = r_tag;
    w_any_swap = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if ((i[0] == r_phase) && ((i + 1) < int'(r_count))) begin
        // Strict compare only: equal keys never move, which keeps the sort stable
        if (r_desc ? (r_key[i] < r_key[i+1]) : (r_key[i] > r_key[i+1])) begin
          w_nkey[i]   = r_key[i+1];
          w_nkey[i+1] = r_key[i];
          w_ntag[i]   = r_tag[i+1];
          w_ntag[i+1] = r_tag[i];
          w_any_swap  = 1'b1;
        end
      end
    end
  end

  // Cell storage: written on accepted beats while loading, rewritten each sort phase
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_key[r_count[IW-1:0]] <= in_key;
      r_tag[r_count[IW-1:0]] <= in_tag;
    end else if (r_state == ST_SORT) begin
      r_key <= w_nkey;
      r_tag <= w_ntag;
    end
  end

  // Control FSM with registered stream outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_LOAD;
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_phases  <= '0;
      r_phase   <= 1'b0;
      r_quiet   <= 1'b0;
      r_desc    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_key   <= '0;
      out_tag   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            r_count <= r_count + CW'(1);
            if (r_count == '0) r_desc <= in_descend;
            if (w_close) begin
              r_state  <= ST_SORT;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              r_phase  <= 1'b0;
              r_phases <= '0;
              r_quiet  <= 1'b0;
            end
          end
        end
        ST_SORT: begin
          r_phase  <= ~r_phase;
          r_phases <= r_phases + CW'(1);
          r_quiet  <= ~w_any_swap;
          if (w_sort_done) begin
            // Take element 0 from the post-phase view so a final swap is not lost
            r_state   <= ST_DRAIN;
            r_rd_ptr  <= '0;
            out_valid <= 1'b1;
            out_key   <= w_nkey[0];
            out_tag   <= w_ntag[0];
            out_last  <= (r_count == CW'(1));
          end
        end
        ST_DRAIN: begin
          if (w_out_hs) begin
            if (out_last) begin
              r_state   <= ST_LOAD;
              r_count   <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              r_rd_ptr <= w_rd_next;
              out_key  <= r_key[w_rd_next[IW-1:0]];
              out_tag  <= r_tag[w_rd_next[IW-1:0]];
              out_last <= (w_rd_next == (r_count - CW'(1)));
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_sort_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_sort_stream
// Brief    : Directed self-checking bench for systolic_sort_stream.
// Revision : 1.0  initial release
// ============================================================================
module tb_systolic_sort_stream;

  localparam int DEPTH = 64;
  localparam int KW    = 32;
  localparam int TW    = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [KW-1:0] in_key;
  logic [TW-1:0] in_tag;
  logic          in_last;
  logic          in_descend;
  logic          out_valid;
  logic          out_ready;
  logic [KW-1:0] out_key;
  logic [TW-1:0] out_tag;
  logic          out_last;
  logic          busy;

  systolic_sort_stream #(.DEPTH(DEPTH), .KEY_W(KW), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_key     (in_key),
    .in_tag     (in_tag),
    .in_last    (in_last),
    .in_descend (in_descend),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_key    (out_key),
    .out_tag    (out_tag),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int sort_cycles;
  bit stall_en;
  logic [KW-1:0] vk [DEPTH];
  logic [TW-1:0] vt [DEPTH];
  logic [KW-1:0] ek [DEPTH];
  logic [TW-1:0] et [DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present n beats back to back; direction only valid on the first beat
  task automatic load(input int n, input bit desc, input bit use_last);
    for (int i = 0; i < n; i++) begin
      in_valid   = 1'b1;
      in_key     = vk[i];
      in_tag     = vt[i];
      in_descend = (i == 0) ? desc : ~desc;
      in_last    = use_last && (i == n - 1);
      check("in_ready_load", in_ready, 1);
      tick;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Count cycles between batch close and first out_valid
  task automatic wait_sort;
    bit ready_seen;
    bit idle_seen;
    ready_seen  = 1'b0;
    idle_seen   = 1'b0;
    sort_cycles = 0;
    while (!out_valid && sort_cycles < 200) begin
      ready_seen |= in_ready;
      idle_seen  |= ~busy;
      sort_cycles++;
      tick;
    end
    check("sort_exit", out_valid, 1);
    check("in_ready_in_sort", ready_seen, 0);
    check("busy_in_sort", idle_seen, 0);
  endtask

  task automatic drain(input int n);
    for (int j = 0; j < n; j++) begin
      if (stall_en) begin
        int s;
        s = $urandom_range(0, 2);
        out_ready = 1'b0;
        repeat (s) begin
          tick;
          check("stall_key", out_key, ek[j]);
          check("stall_tag", out_tag, et[j]);
        end
      end
      out_ready = 1'b1;
      check("out_valid", out_valid, 1);
      check("out_key", out_key, ek[j]);
      check("out_tag", out_tag, et[j]);
      check("out_last", out_last, (j == n - 1));
      check("in_ready_drain", in_ready, 0);
      tick;
    end
    out_ready = 1'b0;
    check("out_valid_done", out_valid, 0);
    check("in_ready_done", in_ready, 1);
    check("busy_done", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_key = '0; in_tag = '0; in_last = 1'b0;
    in_descend = 1'b0; out_ready = 1'b0; stall_en = 1'b0;
    repeat (2) tick;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_key", out_key, 0);
    rst_n = 1'b1;
    tick;

    // 1: ascending 5,3,9,1
    vk[0] = 5; vk[1] = 3; vk[2] = 9; vk[3] = 1;
    vt[0] = 0; vt[1] = 1; vt[2] = 2; vt[3] = 3;
    ek[0] = 1; ek[1] = 3; ek[2] = 5; ek[3] = 9;
    et[0] = 3; et[1] = 1; et[2] = 0; et[3] = 2;
    load(4, 1'b0, 1'b1);
    wait_sort;
    check("t1_sort_bound", (sort_cycles >= 2 && sort_cycles <= 5), 1);
    drain(4);

    // 2: descending with ties, stable order
    vk[0] = 7; vk[1] = 7; vk[2] = 2; vk[3] = 7;
    vt[0] = 8'hA; vt[1] = 8'hB; vt[2] = 8'hC; vt[3] = 8'hD;
    ek[0] = 7; ek[1] = 7; ek[2] = 7; ek[3] = 2;
    et[0] = 8'hA; et[1] = 8'hB; et[2] = 8'hD; et[3] = 8'hC;
    load(4, 1'b1, 1'b1);
    wait_sort;
    drain(4);

    // 3: presorted full batch, closes on DEPTH-th beat without in_last
    for (int i = 0; i < DEPTH; i++) begin
      vk[i] = i; vt[i] = TW'(i) ^ 8'h5A; ek[i] = vk[i]; et[i] = vt[i];
    end
    load(DEPTH, 1'b0, 1'b0);
    wait_sort;
    check("t3_sort_cycles", sort_cycles, 2);
    drain(DEPTH);

    // 4: reversed full batch, ascending, with consumer stalls
    for (int i = 0; i < DEPTH; i++) begin
      vk[i] = KW'(DEPTH - 1 - i); vt[i] = TW'(i);
      ek[i] = KW'(i); et[i] = TW'(DEPTH - 1 - i);
    end
    stall_en = 1'b1;
    load(DEPTH, 1'b0, 1'b1);
    wait_sort;
    check("t4_sort_bound", (sort_cycles >= 1 && sort_cycles <= DEPTH + 1), 1);
    drain(DEPTH);

    // 5: single beat with maximal key
    vk[0] = 32'hFFFF_FFFF; vt[0] = 8'h77; ek[0] = vk[0]; et[0] = vt[0];
    load(1, 1'b0, 1'b1);
    wait_sort;
    check("t5_sort_cycles", sort_cycles, 2);
    drain(1);

    // 5b: stalled multi-beat descending batch
    vk[0] = 10; vk[1] = 40; vk[2] = 20; vk[3] = 30; vk[4] = 0;
    vt[0] = 1; vt[1] = 2; vt[2] = 3; vt[3] = 4; vt[4] = 5;
    ek[0] = 40; ek[1] = 30; ek[2] = 20; ek[3] = 10; ek[4] = 0;
    et[0] = 2; et[1] = 4; et[2] = 3; et[3] = 1; et[4] = 5;
    load(5, 1'b1, 1'b1);
    wait_sort;
    drain(5);
    stall_en = 1'b0;

    // 6: reset in the middle of draining
    vk[0] = 30; vk[1] = 10; vk[2] = 20;
    vt[0] = 0; vt[1] = 1; vt[2] = 2;
    load(3, 1'b0, 1'b1);
    wait_sort;
    check("t6_first_key", out_key, 10);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("t6_out_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_in_ready", in_ready, 1);
    vk[0] = 2; vk[1] = 1; vt[0] = 8'h20; vt[1] = 8'h10;
    ek[0] = 1; ek[1] = 2; et[0] = 8'h10; et[1] = 8'h20;
    load(2, 1'b0, 1'b1);
    wait_sort;
    drain(2);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
`default_nettype wire
